ula_multiciclo: RTL and testbench
=================================

Name: ula_multiciclo

Overview:
Parametrised, registered-output ALU for the ARM-32bit datapath. It generalises the combinational ULA to width LARGURA and uses the same CTRLOpULA encoding and NZCV flag semantics. Add, subtract and logic operations complete in one cycle. MUL and DIV run as iterative multi-cycle engines (shift-add and restoring division) behind a start/busy/done handshake. Divide-by-zero is detected and reported.

Parameters:
LARGURA, 32, operand/result width in bits (>=4)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Iniciar  input  1  start request; accepted only when Ocupado=0
CTRLOpULA  input  4  operation code, sampled on accept
Dado1  input  LARGURA  operand A, sampled on accept
Dado2  input  LARGURA  operand B, sampled on accept
Ocupado  output  1  high while a MUL/DIV iteration is in progress
Pronto  output  1  one-cycle pulse: SaidaULA/NovasFlags updated this cycle
SaidaULA  output  LARGURA  registered result
NovasFlags  output  4  {N,Z,C,V} of the last completed operation
DivPorZero  output  1  registered; 1 when the last completed op was DIV with Dado2=0

Behaviour:
- Opcodes: 0 Soma A+B; 1 Sub1 A-B; 2 Sub2 B-A; 3 Mul low LARGURA bits of A*B (unsigned); 4 Div floor(A/B) (unsigned); 5 Not ~B; 6 And; 7 Or; 8 Xor; 9-15 invalid.
- Flags:
  - N = result MSB; Z = (result==0).
  - Soma: C = carry out; V = (A.msb==B.msb) && (R.msb!=A.msb).
  - Sub1: C = NOT borrow (1 when A>=B unsigned); V = (A.msb!=B.msb) && (R.msb==B.msb).
  - Sub2: C = NOT borrow (1 when B>=A); V = (A.msb!=B.msb) && (R.msb==A.msb).
  - All other ops: C=V=0.
- Reset: state OCIOSO; SaidaULA=0, NovasFlags=0, Pronto=0, Ocupado=0, DivPorZero=0; iteration counter and internal operands cleared.
- FSM states:
  - OCIOSO: Iniciar=1 with single-cycle op (0,1,2,5-8, invalid, or Div with Dado2=0) -> compute and register result at the next edge. Pronto=1 in cycle t+1; stay OCIOSO.
  - OCIOSO: Iniciar=1 with Mul, or Div with Dado2!=0 -> latch operands, counter=0, go CALCULA.
  - CALCULA: one iteration per cycle, LARGURA iterations, Ocupado=1 throughout (cycles t+1..t+LARGURA). After the last iteration go CONCLUI.
  - CONCLUI: register result and flags, Pronto=1 in cycle t+LARGURA+1, Ocupado=0; return to OCIOSO.
  - A new Iniciar is accepted in the same cycle Pronto is high.
- Throughput: single-cycle ops accept Iniciar every cycle while OCIOSO (back-to-back, one result per cycle).
- Iniciar while Ocupado=1: ignored. No queuing; in-flight operands are unaffected by input changes.
- Div by zero: latency 1; SaidaULA = all ones; DivPorZero=1; flags N=1, Z=0, C=0, V=0.
- DivPorZero is updated on every Pronto: 1 only for DIV with Dado2=0, otherwise cleared.
- Invalid opcode: latency 1; result 0; flags 0100.
- Outputs hold their last values between Pronto pulses.
- Reset mid-operation: aborts at the next edge; no Pronto for the aborted op; all outputs return to reset values.
- Arithmetic widths:
  - Add/sub use a (LARGURA+1)-bit intermediate.
  - Multiplier uses a 2*LARGURA accumulator; the high half is discarded.
  - Divider keeps a LARGURA+1 partial remainder; the remainder itself is not output.
  - Counter width is clog2(LARGURA+1).

Test Plan:
1. Soma 0x7FFFFFFF+0x00000001, Iniciar at t -> Pronto at t+1, SaidaULA=0x80000000, NovasFlags=1001 (N=1, V=1).
2. Sub1 5-5 -> 0x00000000, flags 0110. Next cycle Sub2 with Dado1=1, Dado2=0 -> 0xFFFFFFFF, flags 1000. Pronto in consecutive cycles.
3. Mul 0x00010000*0x00010000 at t -> Ocupado=1 for cycles t+1..t+32, Pronto at t+33, SaidaULA=0, flags 0100. Iniciar pulsed at t+5 with Xor is ignored (no extra Pronto).
4. Div 100/7 -> SaidaULA=14, Pronto at t+33, DivPorZero=0. Div 5/0 -> Pronto at t+1, SaidaULA=0xFFFFFFFF, DivPorZero=1, flags 1000.
5. Div 0xFFFFFFFF/3 started, Reset asserted at t+10 -> at t+11 Ocupado=0, SaidaULA=0, NovasFlags=0. No Pronto through t+40.
6. Back-to-back: Iniciar held high for 4 cycles with And, Or, Xor, Not on 0xF0F0F0F0/0x0FF00FF0 -> four consecutive Pronto pulses with results 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0xF00FF00F.

Source files
------------

// File: rtl/ula_multiciclo.sv
// Registered-output ALU for the ARM-32bit datapath: single-cycle add/sub/logic,
// iterative shift-add MUL and restoring DIV behind an Iniciar/Ocupado/Pronto handshake.
module ula_multiciclo #(
  parameter int LARGURA = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Iniciar,
  input  logic [3:0]         CTRLOpULA,
  input  logic [LARGURA-1:0] Dado1,
  input  logic [LARGURA-1:0] Dado2,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [LARGURA-1:0] SaidaULA,
  output logic [3:0]         NovasFlags,
  output logic               DivPorZero
);

  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, CONCLUI} estado_t;

  estado_t            estado;
  logic [CW-1:0]      contador;
  logic               ehDiv;
  logic [LARGURA-1:0] regA;
  logic [LARGURA-1:0] regLo;
  logic [LARGURA-1:0] regHi;

  logic [LARGURA:0]   soma, sub1, sub2;
  logic [LARGURA-1:0] resUnico;
  logic [3:0]         flagsUnico;
  logic               cUnico, vUnico, dzUnico, longa;

  logic [LARGURA:0]   multSoma, desloc, dif;
  logic               cabe;
  logic [LARGURA-1:0] hiNext, loNext;

  // Result and flags of the ops that finish in a single cycle, straight from the inputs.
  always_comb begin
    soma     = {1'b0, Dado1} + {1'b0, Dado2};
    sub1     = {1'b0, Dado1} - {1'b0, Dado2};
    sub2     = {1'b0, Dado2} - {1'b0, Dado1};
    resUnico = '0;
    cUnico   = 1'b0;
    vUnico   = 1'b0;
    dzUnico  = 1'b0;
    longa    = 1'b0;
    case (CTRLOpULA)
      4'd0: begin
        resUnico = soma[LARGURA-1:0];
        cUnico   = soma[LARGURA];
        vUnico   = (Dado1[LARGURA-1] == Dado2[LARGURA-1]) && (resUnico[LARGURA-1] != Dado1[LARGURA-1]);
      end
      4'd1: begin
        resUnico = sub1[LARGURA-1:0];
        cUnico   = ~sub1[LARGURA];
        vUnico   = (Dado1[LARGURA-1] != Dado2[LARGURA-1]) && (resUnico[LARGURA-1] == Dado2[LARGURA-1]);
      end
      4'd2: begin
        resUnico = sub2[LARGURA-1:0];
        cUnico   = ~sub2[LARGURA];
        vUnico   = (Dado1[LARGURA-1] != Dado2[LARGURA-1]) && (resUnico[LARGURA-1] == Dado1[LARGURA-1]);
      end
      4'd3: longa = 1'b1;
      4'd4: begin
        if (Dado2 == '0) begin
          resUnico = '1;
          dzUnico  = 1'b1;
        end else begin
          longa = 1'b1;
        end
      end
      4'd5: resUnico = ~Dado2;
      4'd6: resUnico = Dado1 & Dado2;
      4'd7: resUnico = Dado1 | Dado2;
      4'd8: resUnico = Dado1 ^ Dado2;
      default: resUnico = '0;
    endcase
    flagsUnico = {resUnico[LARGURA-1], (resUnico == '0), cUnico, vUnico};
  end

  // One iteration of either engine; both leave their final answer in regLo.
  always_comb begin
    multSoma = {1'b0, regHi} + (regLo[0] ? {1'b0, regA} : '0);
    desloc   = {regHi, regLo[LARGURA-1]};
    dif      = desloc - {1'b0, regA};
    cabe     = ~dif[LARGURA];
    if (ehDiv) begin
      hiNext = cabe ? dif[LARGURA-1:0] : desloc[LARGURA-1:0];
      loNext = {regLo[LARGURA-2:0], cabe};
    end else begin
      hiNext = multSoma[LARGURA:1];
      loNext = {multSoma[0], regLo[LARGURA-1:1]};
    end
  end

  // Control FSM; CONCLUI is the Pronto cycle and accepts a new request like OCIOSO.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado     <= OCIOSO;
      contador   <= '0;
      ehDiv      <= 1'b0;
      regA       <= '0;
      regLo      <= '0;
      regHi      <= '0;
      Ocupado    <= 1'b0;
      Pronto     <= 1'b0;
      SaidaULA   <= '0;
      NovasFlags <= '0;
      DivPorZero <= 1'b0;
    end else begin
      Pronto <= 1'b0;
      case (estado)
        OCIOSO, CONCLUI: begin
          estado <= OCIOSO;
          if (Iniciar) begin
            if (longa) begin
              ehDiv    <= (CTRLOpULA == 4'd4);
              regA     <= (CTRLOpULA == 4'd4) ? Dado2 : Dado1;
              regLo    <= (CTRLOpULA == 4'd4) ? Dado1 : Dado2;
              regHi    <= '0;
              contador <= '0;
              Ocupado  <= 1'b1;
              estado   <= CALCULA;
            end else begin
              SaidaULA   <= resUnico;
              NovasFlags <= flagsUnico;
              DivPorZero <= dzUnico;
              Pronto     <= 1'b1;
            end
          end
        end
        CALCULA: begin
          regHi    <= hiNext;
          regLo    <= loNext;
          contador <= contador + 1'b1;
          if (contador == CW'(LARGURA - 1)) begin
            SaidaULA   <= loNext;
            NovasFlags <= {loNext[LARGURA-1], (loNext == '0), 2'b00};
            DivPorZero <= 1'b0;
            Pronto     <= 1'b1;
            Ocupado    <= 1'b0;
            estado     <= CONCLUI;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: directed cases plus randomized ops checked
// against a plain-arithmetic reference model; a negedge monitor pops on every Pronto.
module tb_ula_multiciclo;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         dz;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar;
  logic [3:0]   ctrlOp;
  logic [W-1:0] dado1, dado2;
  logic         ocupado, pronto, divPorZero;
  logic [W-1:0] saida;
  logic [3:0]   flags;

  exp_t sbQ[$];
  exp_t monExp;
  int   nChecks = 0;
  int   nFails  = 0;

  ula_multiciclo #(.LARGURA(W)) dut (
    .Clock(clock), .Reset(reset), .Iniciar(iniciar), .CTRLOpULA(ctrlOp),
    .Dado1(dado1), .Dado2(dado2), .Ocupado(ocupado), .Pronto(pronto),
    .SaidaULA(saida), .NovasFlags(flags), .DivPorZero(divPorZero)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: unsigned/signed integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      s;
    logic [63:0] wide;
    logic        c = 1'b0;
    logic        v = 1'b0;
    e.dz  = 1'b0;
    e.res = '0;
    case (op)
      4'd0: begin
        wide = {32'b0, a} + {32'b0, b};
        e.res = wide[W-1:0]; c = wide[W];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        e.res = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: begin
        e.res = b - a; c = (b >= a);
        s = sb - sa; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        wide = {32'b0, a} * {32'b0, b};
        e.res = wide[W-1:0];
      end
      4'd4: begin
        if (b == 0) begin e.res = '1; e.dz = 1'b1; end
        else e.res = a / b;
      end
      4'd5: e.res = ~b;
      4'd6: e.res = a & b;
      4'd7: e.res = a | b;
      4'd8: e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.flags = {e.res[W-1], e.res == 0, c, v};
    return e;
  endfunction

  function automatic int latencyOf(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd3 || (op == 4'd4 && b != 0)) ? W + 1 : 1;
  endfunction

  task automatic pushConst(input logic [W-1:0] r, input logic [3:0] f, input logic dz);
    exp_t e;
    e.res = r; e.flags = f; e.dz = dz;
    sbQ.push_back(e);
  endtask

  // Issue one op at a negedge and wait (bounded) for its Pronto, checking latency and Ocupado.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int expLat;
    expLat  = latencyOf(op, b);
    iniciar = 1'b1; ctrlOp = op; dado1 = a; dado2 = b;
    @(negedge clock);
    iniciar = 1'b0;
    lat = 1;
    while (!pronto && lat < 100) begin
      checkOutput("ocupadoBusy", W'(ocupado), W'(1'b1));
      @(negedge clock);
      lat++;
    end
    checkOutput("latency", W'(lat), W'(expLat));
    checkOutput("ocupadoAtPronto", W'(ocupado), W'(1'b0));
  endtask

  task automatic runModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    sbQ.push_back(model(op, a, b));
    applyStimulus(op, a, b);
  endtask

  // Drive one single-cycle op with Iniciar left high; the caller lowers it after a burst.
  task automatic issueSingle(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    iniciar = 1'b1; ctrlOp = op; dado1 = a; dado2 = b;
    @(negedge clock);
    checkOutput("prontoBurst", W'(pronto), W'(1'b1));
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset && pronto) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpectedPronto: got Pronto=1, expected no result at %0t", $time);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("saida", saida, monExp.res);
        checkOutput("flags", W'(flags), W'(monExp.flags));
        checkOutput("divPorZero", W'(divPorZero), W'(monExp.dz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           lat;
    int           nPronto;

    reset = 1'b1; iniciar = 1'b0; ctrlOp = '0; dado1 = '0; dado2 = '0;
    repeat (3) @(negedge clock);
    checkOutput("resetSaida", saida, '0);
    checkOutput("resetFlags", W'(flags), '0);
    checkOutput("resetPronto", W'(pronto), '0);
    checkOutput("resetOcupado", W'(ocupado), '0);
    checkOutput("resetDz", W'(divPorZero), '0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed cases");
    pushConst(32'h8000_0000, 4'b1001, 1'b0);
    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    pushConst(32'h0000_0000, 4'b0110, 1'b0);
    applyStimulus(4'd1, 32'd5, 32'd5);
    pushConst(32'hFFFF_FFFF, 4'b1000, 1'b0);
    applyStimulus(4'd2, 32'd1, 32'd0);

    // Mul with an ignored Xor request at t+5 and operand changes while busy.
    pushConst(32'h0000_0000, 4'b0100, 1'b0);
    iniciar = 1'b1; ctrlOp = 4'd3; dado1 = 32'h0001_0000; dado2 = 32'h0001_0000;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (4) @(negedge clock);
    iniciar = 1'b1; ctrlOp = 4'd8; dado1 = 32'h1234_5678; dado2 = 32'h0F0F_0F0F;
    @(negedge clock);
    iniciar = 1'b0;
    lat = 6;
    while (!pronto && lat < 100) begin
      checkOutput("mulOcupado", W'(ocupado), W'(1'b1));
      @(negedge clock);
      lat++;
    end
    checkOutput("mulLatency", W'(lat), W'(W + 1));
    @(negedge clock);

    pushConst(32'd14, 4'b0000, 1'b0);
    applyStimulus(4'd4, 32'd100, 32'd7);
    pushConst(32'hFFFF_FFFF, 4'b1000, 1'b1);
    applyStimulus(4'd4, 32'd5, 32'd0);
    pushConst(32'h0000_0000, 4'b0100, 1'b0);
    applyStimulus(4'd12, 32'hDEAD_BEEF, 32'h1);

    // Reset in the middle of a division.
    iniciar = 1'b1; ctrlOp = 4'd4; dado1 = 32'hFFFF_FFFF; dado2 = 32'd3;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abortOcupado", W'(ocupado), '0);
    checkOutput("abortSaida", saida, '0);
    checkOutput("abortFlags", W'(flags), '0);
    checkOutput("abortDz", W'(divPorZero), '0);
    nPronto = 0;
    repeat (29) begin
      @(negedge clock);
      if (pronto) nPronto++;
    end
    checkOutput("abortNoPronto", W'(nPronto), '0);

    // Back-to-back single-cycle ops.
    pushConst(32'h00F0_00F0, 4'b0000, 1'b0);
    pushConst(32'hFFF0_FFF0, 4'b1000, 1'b0);
    pushConst(32'hFF00_FF00, 4'b1000, 1'b0);
    pushConst(32'hF00F_F00F, 4'b1000, 1'b0);
    issueSingle(4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issueSingle(4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issueSingle(4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issueSingle(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    iniciar = 1'b0;
    @(negedge clock);

    $display("[TB] randomized ops");
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: a = {1'b0, a[W-2:0]};
        default: ;
      endcase
      runModel(op, a, b);
    end

    $display("[TB] randomized bursts");
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        a = $urandom();
        b = $urandom();
        case ($urandom_range(0, 8))
          0: op = 4'd0;
          1: op = 4'd1;
          2: op = 4'd2;
          3: op = 4'd5;
          4: op = 4'd6;
          5: op = 4'd7;
          6: op = 4'd8;
          7: begin op = 4'd4; b = '0; end
          default: op = 4'($urandom_range(9, 15));
        endcase
        sbQ.push_back(model(op, a, b));
        issueSingle(op, a, b);
      end
      iniciar = 1'b0;
      @(negedge clock);
    end

    repeat (3) @(negedge clock);
    checkOutput("scoreboardDrained", W'(sbQ.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
